// File: rtl/alureg_tx.sv
// Serial readback transmitter for the ALU result register: snapshots the byte on request and
// shifts it out LSB first as start / 8 data / optional even parity / stop, idle-high line.
module alureg_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] data_in,
    output logic       ack,
    output logic       busy,
    output logic       txd
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    // txd, busy and ack are set from the state being entered, so every output is a flop.
    // NOTE: all state here is updated with <= so every branch sees pre-edge values;
    // blocking assignments would make the shift/txd pairing depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            txd        <= 1'b1;
        end else begin
            ack <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        shift_reg  <= data_in;
                        parity_bit <= ^data_in;
                        baud_cnt   <= '0;
                        state      <= START;
                        txd        <= 1'b0;
                        busy       <= 1'b1;
                        ack        <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        txd   <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                txd   <= parity_bit;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            txd <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        txd   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alureg_tx.sv
// Bench for alureg_tx: one instance without parity, one with, both at 4 clocks per bit;
// expected line bits are queued when a request is driven and popped cycle by cycle.
module tb_alureg_tx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       ack0, busy0, txd0;
    logic       ack1, busy1, txd1;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    alureg_tx #(.CLKS_PER_BIT(N), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .data_in(data0),
        .ack(ack0), .busy(busy0), .txd(txd0)
    );

    alureg_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .data_in(data1),
        .ack(ack1), .busy(busy1), .txd(txd1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    endtask

    function automatic logic g_txd(input int sel);
        return (sel != 0) ? txd1 : txd0;
    endfunction
    function automatic logic g_busy(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction
    function automatic logic g_ack(input int sel);
        return (sel != 0) ? ack1 : ack0;
    endfunction

    task automatic drive(input int sel, input logic r, input logic [7:0] d);
        if (sel != 0) begin req1 = r; data1 = d; end
        else          begin req0 = r; data0 = d; end
    endtask

    task automatic push_frame(input logic [7:0] b, input bit par);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (par) exp_q.push_back(^b);
        exp_q.push_back(1'b1);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after stop.
    task automatic run_frame(input int sel, input logic [7:0] b, input bit keep_req,
                             input bit inject);
        int cyc;
        bit exp_bit;
        int nbits;
        drive(sel, 1'b1, b);
        push_frame(b, sel != 0);
        nbits = exp_q.size();
        @(negedge clk);
        check("ack_pulse", g_ack(sel), 1'b1);
        if (!keep_req) drive(sel, 1'b0, b);
        cyc = 0;
        for (int k = 0; k < nbits; k++) begin
            exp_bit = exp_q.pop_front();
            for (int c = 0; c < N; c++) begin
                if (cyc != 0) begin
                    @(negedge clk);
                    check("ack_low", g_ack(sel), 1'b0);
                end
                check("txd", g_txd(sel), exp_bit);
                check("busy", g_busy(sel), 1'b1);
                if (inject && cyc == 10) drive(sel, 1'b1, 8'hFF);
                if (inject && cyc == 11) drive(sel, 1'b0, 8'hFF);
                if (inject && cyc >= 20) drive(sel, 1'b0, 8'($urandom_range(0, 255)));
                cyc++;
            end
        end
        @(negedge clk);
        check("idle_busy", g_busy(sel), 1'b0);
        check("idle_txd", g_txd(sel), 1'b1);
        check("idle_ack", g_ack(sel), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_txd0", txd0, 1'b1);
        check("rst_busy0", busy0, 1'b0);
        check("rst_ack0", ack0, 1'b0);
        check("rst_txd1", txd1, 1'b1);
        check("rst_busy1", busy1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i % 10 == 9) begin
                check("quiet_txd", txd0, 1'b1);
                check("quiet_busy", busy0, 1'b0);
                check("quiet_ack", ack0, 1'b0);
            end
        end

        // Basic frame with a rejected request and data_in noise mid-frame.
        run_frame(0, 8'hA5, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Back-to-back: req held through the first frame, second accepted after one idle cycle.
        run_frame(0, 8'h00, 1'b1, 1'b0);
        run_frame(0, 8'hFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Parity instance: odd and even popcounts.
        run_frame(1, 8'h07, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run_frame(1, 8'h03, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset during data bit 3 (cycles 4N..5N-1), checked before any clock edge.
        drive(0, 1'b1, 8'h81);
        @(negedge clk);
        check("ack_pre_rst", ack0, 1'b1);
        drive(0, 1'b0, 8'h81);
        repeat (4 * N + 1) @(negedge clk);
        check("busy_pre_rst", busy0, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_txd", txd0, 1'b1);
        check("rst_mid_busy", busy0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(0, 8'h3C, 1'b0, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alureg_tx.md
# alureg_tx

Serial readback transmitter for the 8-bit ALU result register: on request it snapshots the register's current value and shifts it out as an asynchronous serial frame on a single wire, LSB first, with start bit, optional even parity and one stop bit. It sits on the read side of the ALU register, giving debug and host logic a pin-level view of results without loading the datapath. The register keeps being written normally during a transfer.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range ≥ 2.
- PARITY_EN, 0, 1 = insert even-parity bit between data and stop; 0 = no parity bit.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  transmit request, level-sampled at rising edge of clk.
- data_in  in  8  ALU register value to send; sampled only on accept.
- ack  out  1  one-cycle pulse: request accepted, data_in captured.
- busy  out  1  high while a frame is in progress.
- txd  out  1  serial line; idle/mark = 1.

## Operation
- States: IDLE, START, DATA, PARITY (only when PARITY_EN=1), STOP.
- Reset (async): state=IDLE, txd=1, busy=0, ack=0, shift register=0, bit counter=0, baud counter=0.
- IDLE: txd=1, busy=0. req=1 at an edge → capture data_in into shift register, compute even parity (XOR of the 8 bits), load baud counter, go START, ack=1 for that following cycle.
- START: txd=0 for CLKS_PER_BIT cycles → DATA.
- DATA: txd=shift_reg[0]; after CLKS_PER_BIT cycles shift right by one, increment bit counter; after the 8th bit → PARITY if PARITY_EN else STOP.
- PARITY: txd=parity bit (1 when the captured byte has an odd number of ones) for CLKS_PER_BIT cycles → STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles → IDLE.
- busy=1 in every state except IDLE.
- req while busy=1: ignored, no ack, not queued; the requester must hold or re-assert req.
- Changes on data_in after capture do not affect the frame in flight.
- Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Bit counter: 3 bits, wraps 7→0 on DATA exit.

## Timing
- req=1, busy=0 sampled at edge E0 → in the cycle after E0: ack=1, busy=1, txd=0. ack is low again one cycle later.
- With N=CLKS_PER_BIT and the cycle after E0 as cycle 0:
  - start bit in cycles 0..N-1;
  - data bit i in cycles (i+1)N..(i+2)N-1;
  - parity bit, if enabled, in cycles 9N..10N-1;
  - stop bit occupies the last N cycles.
- busy falls on the cycle after the stop bit: cycle 10N without parity, 11N with parity.
- req high on the edge where busy is already 0 is accepted, so continuous req gives frames separated by exactly one idle cycle of txd=1.
- rst asserted mid-frame: txd=1, busy=0 immediately (no clock edge needed). The frame is abandoned with no completion indication. The first req after rst deasserts is accepted normally.
- Output latency req→txd start bit: 1 cycle. All outputs are registered.

## Test plan
- Reset values: assert rst with clk running → txd=1, busy=0, ack=0. Release rst, hold req=0 for 50 cycles → outputs unchanged.
- Basic frame, CLKS_PER_BIT=4, PARITY_EN=0: data_in=0xA5, req pulsed one cycle → one ack pulse, then txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high exactly 40 cycles.
- Busy rejection: during the 0xA5 frame, pulse req with data_in=0xFF → no ack, frame bits unchanged. Change data_in mid-frame → no effect on txd.
- Back-to-back: hold req=1 with data_in=0x00 then 0xFF → two frames, exactly one idle cycle (txd=1, busy=0) between the stop bit of the first and the start bit of the second; two ack pulses.
- Parity, PARITY_EN=1, CLKS_PER_BIT=4: send 0x07 → parity bit 1; send 0x03 → parity bit 0; busy high 44 cycles per frame.
- Reset mid-frame: assert rst during data bit 3 → txd=1 and busy=0 without a clock edge. Then req with 0x3C → clean full frame LSB-first 0,0,1,1,1,1,0,0 between start and stop bits.
